// File: rtl/sid_mix_if.sv
// sid_mix_if: mix scheduler handshake and data bus; master drives the voice/filter inputs, slave is the scheduler
interface sid_mix_if;
  logic        sample_tick;
  logic [35:0] wave_bus;
  logic [23:0] env_bus;
  logic [2:0]  flt_route;
  logic        mute3;
  logic [3:0]  vol;
  logic [11:0] flt_out;
  logic [11:0] flt_in;
  logic [11:0] audio;
  logic        sample_valid;
  logic        busy;
  logic        overrun;
  modport master (
    output sample_tick, wave_bus, env_bus, flt_route, mute3, vol, flt_out,
    input  flt_in, audio, sample_valid, busy, overrun
  );
  modport slave (
    input  sample_tick, wave_bus, env_bus, flt_route, mute3, vol, flt_out,
    output flt_in, audio, sample_valid, busy, overrun
  );
endinterface

// File: rtl/sid_mix_sched.sv
// sid_mix_sched: one shared 12x8 multiplier time-multiplexed over three voices, filter/direct mix, master volume
// SID_MIX_ROUND_EN selects round-half-up with saturation for the 8-bit mix instead of truncation.
module sid_mix_sched #(
  parameter int ACC_W     = 22,
  parameter int FLT_SHIFT = 8
) (
  input logic     clk,
  input logic     reset,
  sid_mix_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, V1 = 3'd1, V2 = 3'd2, V3 = 3'd3, ACC = 3'd4, MIX = 3'd5, VOL = 3'd6;
  logic [2:0]       state;
  logic [35:0]      w_s;
  logic [23:0]      e_s;
  logic [2:0]       route_s;
  logic             mute_s;
  logic [3:0]       vol_s;
  logic [11:0]      fo_s;
  logic [19:0]      prod;
  logic [ACC_W-1:0] flt_acc, dir_acc, mix;
  logic [11:0]      w_sel;
  logic [7:0]       e_sel, m8;
  logic             acc_en, acc_flt, drop;
  assign w_sel   = state == V1 ? w_s[11:0] : state == V2 ? w_s[23:12] : w_s[35:24];
  assign e_sel   = state == V1 ? e_s[7:0]  : state == V2 ? e_s[15:8]  : e_s[23:16];
  assign acc_en  = state == V2 || state == V3 || state == ACC;
  assign acc_flt = state == V2 ? route_s[0] : state == V3 ? route_s[1] : route_s[2];
  assign drop    = state == ACC && !route_s[2] && mute_s;
`ifdef SID_MIX_ROUND_EN
  logic [ACC_W:0] rnd;
  assign rnd = {1'b0, mix} + (ACC_W+1)'(1 << 13);
  assign m8  = (rnd >> 14) > (ACC_W+1)'(255) ? 8'hff : 8'(rnd >> 14);
`else
  assign m8  = 8'(mix >> 14);
`endif
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      w_s              <= '0;
      e_s              <= '0;
      route_s          <= '0;
      mute_s           <= 1'b0;
      vol_s            <= '0;
      fo_s             <= '0;
      prod             <= '0;
      flt_acc          <= '0;
      dir_acc          <= '0;
      mix              <= '0;
      bus.flt_in       <= '0;
      bus.audio        <= '0;
      bus.sample_valid <= 1'b0;
      bus.overrun      <= 1'b0;
    end else begin
      state            <= state == IDLE ? (bus.sample_tick ? V1 : IDLE) : state == VOL ? IDLE : state + 3'd1;
      bus.sample_valid <= state == VOL;
      if (bus.sample_tick && state != IDLE) bus.overrun <= 1'b1;
      if (state == IDLE && bus.sample_tick) begin
        w_s     <= bus.wave_bus;
        e_s     <= bus.env_bus;
        route_s <= bus.flt_route;
        mute_s  <= bus.mute3;
        vol_s   <= bus.vol;
        fo_s    <= bus.flt_out;
        flt_acc <= '0;
        dir_acc <= '0;
      end
      if (state == V1 || state == V2 || state == V3) prod <= 20'(w_sel) * 20'(e_sel);
      if (acc_en && !drop && acc_flt) flt_acc <= flt_acc + ACC_W'(prod);
      if (acc_en && !drop && !acc_flt) dir_acc <= dir_acc + ACC_W'(prod);
      if (state == MIX) begin
        bus.flt_in <= 12'(flt_acc >> (ACC_W - 12));
        mix        <= dir_acc + (ACC_W'(fo_s) << FLT_SHIFT);
      end
      if (state == VOL) bus.audio <= 12'(vol_s) * 12'(m8);
    end
  end
endmodule

// File: tb/tb_sid_mix_sched.sv
// tb_sid_mix_sched: directed vectors with hand-computed expectations for sid_mix_sched
module tb_sid_mix_sched;
  logic clk = 1'b0;
  logic reset;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  sid_mix_if bus();
  sid_mix_sched dut (.clk(clk), .reset(reset), .bus(bus));
`ifdef SID_MIX_ROUND_EN
  localparam int FULL = 960, MIXA = 119;
`else
  localparam int FULL = 945, MIXA = 112;
`endif
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic set_in(input logic [35:0] w, input logic [23:0] e, input logic [2:0] r,
                        input logic m, input logic [3:0] v, input logic [11:0] f);
    bus.wave_bus = w; bus.env_bus = e; bus.flt_route = r; bus.mute3 = m; bus.vol = v; bus.flt_out = f;
  endtask
  task automatic run_pass(input string tag, input logic [35:0] w, input logic [23:0] e, input logic [2:0] r,
                          input logic m, input logic [3:0] v, input logic [11:0] f, input int ea, input int ef);
    int k;
    @(negedge clk);
    set_in(w, e, r, m, v, f);
    bus.sample_tick = 1'b1;
    @(posedge clk); #1 bus.sample_tick = 1'b0;
    check({tag, ".busy"}, int'(bus.busy), 1);
    k = 0;
    while (k < 12 && !bus.sample_valid) begin
      @(posedge clk); #1;
      k++;
      if (k == 5) check({tag, ".flt_in_early"}, int'(bus.flt_in), ef);
    end
    check({tag, ".latency"}, k, 6);
    check({tag, ".audio"}, int'(bus.audio), ea);
    check({tag, ".flt_in"}, int'(bus.flt_in), ef);
    check({tag, ".idle"}, int'(bus.busy), 0);
    @(posedge clk); #1;
    check({tag, ".pulse"}, int'(bus.sample_valid), 0);
  endtask
  initial begin
    int nv;
    reset = 1'b1;
    bus.sample_tick = 1'b0;
    set_in('0, '0, '0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("rst.audio", int'(bus.audio), 0);
    check("rst.flt_in", int'(bus.flt_in), 0);
    check("rst.valid", int'(bus.sample_valid), 0);
    check("rst.busy", int'(bus.busy), 0);
    check("rst.overrun", int'(bus.overrun), 0);
    @(negedge clk) reset = 1'b0;
    run_pass("t1", {24'd0, 12'd4095}, {16'd0, 8'd255}, 3'b000, 1'b0, 4'd15, 12'd0, FULL, 0);
    check("t1.overrun", int'(bus.overrun), 0);
    run_pass("t2", {24'd0, 12'd4095}, {16'd0, 8'd255}, 3'b001, 1'b0, 4'd15, 12'd0, 0, 1019);
    run_pass("t3a", {12'd4095, 24'd0}, {8'd255, 16'd0}, 3'b000, 1'b1, 4'd15, 12'd0, 0, 0);
    run_pass("t3b", {12'd4095, 24'd0}, {8'd255, 16'd0}, 3'b100, 1'b1, 4'd15, 12'd0, 0, 1019);
    run_pass("t3c", {12'd4095, 24'd0}, {8'd255, 16'd0}, 3'b000, 1'b0, 4'd15, 12'd0, FULL, 0);
    run_pass("t4a", '0, '0, 3'b000, 1'b0, 4'd15, 12'd4095, FULL, 0);
    run_pass("t4b", '0, '0, 3'b000, 1'b0, 4'd0, 12'd4095, 0, 0);
    run_pass("mixd", {12'd3000, 12'd2000, 12'd1000}, {8'd50, 8'd200, 8'd100}, 3'b010, 1'b0, 4'd7, 12'd100, MIXA, 390);
    // Second tick three cycles into a pass, with the wave inputs changed under it
    @(negedge clk);
    set_in({24'd0, 12'd4095}, {16'd0, 8'd255}, 3'b000, 1'b0, 4'd15, 12'd0);
    bus.sample_tick = 1'b1;
    @(posedge clk); #1 bus.sample_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    set_in('0, '0, 3'b111, 1'b1, 4'd0, 12'd0);
    bus.sample_tick = 1'b1;
    @(posedge clk); #1 bus.sample_tick = 1'b0;
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.sample_valid) nv++;
    end
    check("t5.valids", nv, 1);
    check("t5.audio", int'(bus.audio), FULL);
    check("t5.overrun", int'(bus.overrun), 1);
    repeat (5) @(posedge clk);
    #1 check("t5.overrun_sticky", int'(bus.overrun), 1);
    // Reset lands while the pass is in V3
    @(negedge clk);
    set_in({24'd0, 12'd4095}, {16'd0, 8'd255}, 3'b001, 1'b0, 4'd15, 12'd0);
    bus.sample_tick = 1'b1;
    @(posedge clk); #1 bus.sample_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("t6.audio", int'(bus.audio), 0);
    check("t6.flt_in", int'(bus.flt_in), 0);
    check("t6.busy", int'(bus.busy), 0);
    check("t6.valid", int'(bus.sample_valid), 0);
    check("t6.overrun", int'(bus.overrun), 0);
    @(negedge clk) reset = 1'b0;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.sample_valid) nv++;
    end
    check("t6.no_valid", nv, 0);
    run_pass("t6r", {24'd0, 12'd4095}, {16'd0, 8'd255}, 3'b000, 1'b0, 4'd15, 12'd0, FULL, 0);
    // Reset and tick together: the tick must be dropped
    @(negedge clk);
    reset = 1'b1;
    bus.sample_tick = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
    bus.sample_tick = 1'b0;
    @(posedge clk); #1;
    check("rt.busy", int'(bus.busy), 0);
    check("rt.overrun", int'(bus.overrun), 0);
    check("rt.audio", int'(bus.audio), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
